i2c_slave_bridge_regs: RTL and testbench
========================================

# i2c_slave_bridge_regs

I2C slave register bridge: the device at address 0x66 that the soft I2C master drives. It deserialises I2C writes into a 16-byte register file holding a 32-bit write address, write data and read address. It raises single-cycle write/read requests toward the local bus side. It returns the local-bus read data over I2C reads.

## Interface
- SLAVE_ADDR, 7'h66, 7-bit I2C device address matched against the first byte after START.
- clk_i  input  1  system clock; SCL/SDA are oversampled in this domain.
- rst_ni  input  1  reset, asynchronous, active-low.
- scl_i  input  1  I2C clock from pad; asynchronous.
- sda_i  input  1  I2C data from pad; asynchronous.
- sda_o  output  1  constant 0 (open-drain data value).
- sda_oe_o  output  1  1 = pull SDA low (ACK or data 0), 0 = release.
- bus_waddr_o  output  32  regs 0x00..0x03, MSB first.
- bus_wdata_o  output  32  regs 0x04..0x07, MSB first.
- bus_wr_o  output  1  one-cycle write request.
- bus_raddr_o  output  32  regs 0x08..0x0B, MSB first.
- bus_rd_o  output  1  one-cycle read request.
- bus_rdata_i  input  32  read data from the local bus.
- bus_rvalid_i  input  1  strobe; loads bus_rdata_i into regs 0x0C..0x0F.
- busy_o  output  1  high from matched address ACK until STOP or repeated START.

## Operation
- scl_i and sda_i each pass through a 2-flop synchroniser, then a previous-value flop for edge detection.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are detected in every state, including mid-byte.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- START in any state -> DEV_ADDR, bit counter = 7.
- STOP in any state -> IDLE, sda_oe_o released, partial byte discarded.
- Bits are sampled on synchronised SCL rising edges, MSB first. Slave-driven SDA changes only after SCL falling edges.
- DEV_ADDR, after 8 bits:
  - addr[7:1] == SLAVE_ADDR -> DEV_ACK. sda_oe_o = 1 from the next SCL fall to the following SCL fall.
  - addr[0] = 0 -> PTR. addr[0] = 1 -> RD_BYTE.
  - Mismatch -> IGNORE; no ACK. IGNORE waits for START or STOP.
- PTR:
  - Byte <= 0x0F -> pointer = byte[3:0], ACK, then WR_BYTE.
  - Byte > 0x0F -> NACK, then IGNORE.
- WR_BYTE:
  - Byte is stored at reg[pointer] and ACKed; pointer increments, 0x0F wraps to 0x00.
  - Writes to 0x0C..0x0F are ACKed but discarded.
- RD_BYTE:
  - reg[pointer] is copied into the TX shift register at the SCL fall that starts the byte. Each bit drives sda_oe_o = ~bit.
  - After 8 bits: release SDA, sample master ACK on SCL rise, increment pointer.
  - Master ACK (0) -> next RD_BYTE. Master NACK (1) -> IGNORE until STOP/START.
- Request strobes:
  - Storing pointer 0x07 -> bus_wr_o pulse.
  - Storing pointer 0x0B -> bus_rd_o pulse.
- bus_rvalid_i loads regs 0x0C..0x0F (0x0C = bits 31:24) in the same cycle.
  - If it coincides with an I2C write to 0x0C..0x0F, bus_rvalid_i wins.
  - A byte already in the TX shift register is unaffected.

## Timing
- Reset values: sda_o = 0, sda_oe_o = 0, bus_wr_o = 0, bus_rd_o = 0, busy_o = 0. All registers = 0, FSM = IDLE, pointer = 0.
- SCL edge detection latency: 3 clk_i cycles. Required: SCL high and low phases each >= 8 clk_i cycles.
- ACK drive: sda_oe_o asserts 1 cycle after the detected 8th-bit SCL fall. It deasserts 1 cycle after the next detected SCL fall.
- bus_wr_o / bus_rd_o: exactly 1 cycle, asserted in the cycle after the 8th SCL rise of the triggering byte is detected. The STOP is not awaited.
- bus_waddr_o, bus_wdata_o and bus_raddr_o are stable while the matching strobe is high. They change only on later I2C writes.
- rst_ni low mid-transfer: SDA released immediately (async), all state cleared. The bus resyncs at the next START.

## Test plan
- Write 0x00, then 11 22 33 44 AA BB CC DD, then STOP -> bus_waddr_o = 0x11223344, bus_wdata_o = 0xAABBCCDD, one bus_wr_o pulse, every byte ACKed.
- Write 0x08, then DE AD BE EF -> bus_raddr_o = 0xDEADBEEF, one bus_rd_o pulse. Drive bus_rvalid_i with 0x12345678. Then write 0x0C, repeated START, read 4 bytes (ACK, ACK, ACK, NACK) -> SDA returns 12 34 56 78.
- Address 0x55 + W -> no ACK (sda_oe_o stays 0), no strobes, busy_o = 0.
- Pointer byte 0x20 -> NACK. Subsequent data bytes ignored; registers unchanged.
- Write 0x0F, then 01 02 -> reg 0x0F write ignored, reg 0x00 = 0x02 (wrap). No strobes.
- STOP after 4 bits of a data byte, then rst_ni pulsed mid-ACK -> register unchanged, sda_oe_o = 0 at once, next full transaction succeeds.

Source files
------------

// File: rtl/i2c_slave_bridge_regs_if.sv
// Local-bus side of the I2C register bridge.
//   bus_waddr/bus_wdata : write address/data (regs 0x00..0x07)
//   bus_wr              : one-cycle write request
//   bus_raddr           : read address (regs 0x08..0x0B)
//   bus_rd              : one-cycle read request
//   bus_rdata/bus_rvalid: read return, loaded into regs 0x0C..0x0F
// The bridge issues requests (master); the local bus answers (slave).
interface i2c_slave_bridge_regs_if;
    logic [31:0] bus_waddr;
    logic [31:0] bus_wdata;
    logic        bus_wr;
    logic [31:0] bus_raddr;
    logic        bus_rd;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output bus_waddr, bus_wdata, bus_wr, bus_raddr, bus_rd,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_waddr, bus_wdata, bus_wr, bus_raddr, bus_rd,
        output bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/i2c_slave_bridge_regs.sv
// I2C slave register bridge at device address SLAVE_ADDR.
// I2C writes fill a 16-byte register file (write addr, write data, read addr,
// read data); storing reg 0x07 / 0x0B fires a one-cycle write / read request.
// I2C reads return register contents starting at the current pointer.
// Ports:
//   clk_i, rst_ni   : system clock, async active-low reset
//   scl_i, sda_i    : asynchronous I2C pad inputs (oversampled)
//   sda_o, sda_oe_o : open-drain data (sda_o tied 0, sda_oe_o = pull low)
//   busy_o          : addressed transaction in progress
//   bus             : local-bus request/response interface (master modport)
module i2c_slave_bridge_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h66
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic sda_oe_o,
    output logic busy_o,
    i2c_slave_bridge_regs_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK,
        WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_e;

    state_e      state;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_prev, sda_prev;
    logic [2:0]  bit_cnt;
    logic [6:0]  shreg;
    logic [7:0]  tx;
    logic [3:0]  ptr;
    logic        phase;    // ACK: driving slot; RD_BYTE: all 8 bits sent; RD_ACK: master ACKed
    logic        rw;
    logic        sda_oe, busy, wr_q, rd_q;
    logic [7:0]  regs [16];

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  =  scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s &  scl_prev;
    assign start_det =  scl_s & scl_prev &  sda_prev & ~sda_s;
    assign stop_det  =  scl_s & scl_prev & ~sda_prev &  sda_s;
    assign rx_byte   = {shreg, sda_s};

    // Synchronisers reset to the idle-bus level so reset release never
    // looks like a START.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= '0;
            ptr     <= '0;
            phase   <= 1'b0;
            rw      <= 1'b0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                phase  <= 1'b0;
            end else if (start_det) begin
                state   <= DEV_ADDR;
                bit_cnt <= 3'd7;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                phase   <= 1'b0;
            end else begin
                case (state)
                    DEV_ADDR, PTR, WR_BYTE: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt - 3'd1;
                            phase   <= 1'b0;
                            if (bit_cnt == 3'd0) begin
                                if (state == DEV_ADDR) begin
                                    rw    <= rx_byte[0];
                                    state <= (rx_byte[7:1] == SLAVE_ADDR) ? DEV_ACK : IGNORE;
                                end else if (state == PTR) begin
                                    ptr   <= rx_byte[3:0];
                                    state <= (rx_byte[7:4] == 4'h0) ? PTR_ACK : IGNORE;
                                end else begin
                                    // 0x0C..0x0F belong to the local bus; ACK but drop
                                    if (ptr < 4'hC) regs[ptr] <= rx_byte;
                                    wr_q  <= (ptr == 4'h7);
                                    rd_q  <= (ptr == 4'hB);
                                    ptr   <= ptr + 4'd1;
                                    state <= WR_ACK;
                                end
                            end
                        end
                    end
                    // ACK slot spans from the 8th-bit SCL fall to the next fall
                    DEV_ACK, PTR_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                phase  <= 1'b1;
                                sda_oe <= 1'b1;
                                if (state == DEV_ACK) busy <= 1'b1;
                            end else begin
                                phase   <= 1'b0;
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd7;
                                if (state == DEV_ACK && rw) begin
                                    tx     <= regs[ptr];
                                    sda_oe <= ~regs[ptr][7];
                                    state  <= RD_BYTE;
                                end else begin
                                    state <= (state == DEV_ACK) ? PTR : WR_BYTE;
                                end
                            end
                        end
                    end
                    RD_BYTE: begin
                        if (scl_rise) begin
                            if (bit_cnt == 3'd0) phase <= 1'b1;
                            else                 bit_cnt <= bit_cnt - 3'd1;
                        end else if (scl_fall) begin
                            if (phase) begin
                                phase  <= 1'b0;
                                sda_oe <= 1'b0;
                                state  <= RD_ACK;
                            end else begin
                                tx     <= {tx[6:0], 1'b0};
                                sda_oe <= ~tx[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            ptr <= ptr + 4'd1;
                            if (!sda_s) phase <= 1'b1;
                            else        state <= IGNORE;
                        end else if (scl_fall && phase) begin
                            phase   <= 1'b0;
                            bit_cnt <= 3'd7;
                            tx      <= regs[ptr];
                            sda_oe  <= ~regs[ptr][7];
                            state   <= RD_BYTE;
                        end
                    end
                    default: ;
                endcase
            end
            // Local-bus read return; placed last so it wins over I2C writes
            if (bus.bus_rvalid) begin
                regs[12] <= bus.bus_rdata[31:24];
                regs[13] <= bus.bus_rdata[23:16];
                regs[14] <= bus.bus_rdata[15:8];
                regs[15] <= bus.bus_rdata[7:0];
            end
        end
    end

    assign sda_o         = 1'b0;
    assign sda_oe_o      = sda_oe;
    assign busy_o        = busy;
    assign bus.bus_wr    = wr_q;
    assign bus.bus_rd    = rd_q;
    assign bus.bus_waddr = {regs[0], regs[1], regs[2],  regs[3]};
    assign bus.bus_wdata = {regs[4], regs[5], regs[6],  regs[7]};
    assign bus.bus_raddr = {regs[8], regs[9], regs[10], regs[11]};
endmodule

// File: tb/tb_i2c_slave_bridge_regs.sv
module tb_i2c_slave_bridge_regs;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    logic sda_line, sda_o, sda_oe, busy;

    i2c_slave_bridge_regs_if bif();

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_bridge_regs dut (
        .clk_i(clk), .rst_ni(rst_n), .scl_i(scl), .sda_i(sda_line),
        .sda_o(sda_o), .sda_oe_o(sda_oe), .busy_o(busy), .bus(bif.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Strobe / drive monitors
    int wr_hi = 0, rd_hi = 0, oe_cnt = 0;
    logic [31:0] waddr_at_wr = '0, wdata_at_wr = '0, raddr_at_rd = '0;
    always @(posedge clk) begin
        if (bif.bus_wr) begin
            wr_hi <= wr_hi + 1;
            waddr_at_wr <= bif.bus_waddr;
            wdata_at_wr <= bif.bus_wdata;
        end
        if (bif.bus_rd) begin
            rd_hi <= rd_hi + 1;
            raddr_at_rd <= bif.bus_raddr;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    // Reference model: register file, pointer, expected strobe counts
    logic [7:0] m [16];
    int mp = 0, exp_wr = 0, exp_rd = 0;

    task automatic mdl_reset();
        for (int i = 0; i < 16; i++) m[i] = 8'h00;
        mp = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        clks(2); sda_m = 1'b1; clks(8); scl = 1'b1; clks(10);
        sda_m = 1'b0; clks(10); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        clks(2); sda_m = 1'b0; clks(8); scl = 1'b1; clks(10);
        sda_m = 1'b1; clks(10);
    endtask

    task automatic send_bit(input logic b);
        clks(2); sda_m = b; clks(8); scl = 1'b1; clks(10); scl = 1'b0;
    endtask

    task automatic send8(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic get_ack(output logic a);
        clks(2); sda_m = 1'b1; clks(8); scl = 1'b1; clks(5);
        a = ~sda_line; clks(5); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        send8(b);
        get_ack(a);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic [7:0] v;
        v = '0;
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            clks(10); scl = 1'b1; clks(5);
            v = {v[6:0], sda_line};
            clks(5); scl = 1'b0;
        end
        clks(2); sda_m = nack; clks(8); scl = 1'b1; clks(10); scl = 1'b0;
        clks(2); sda_m = 1'b1;
        d = v;
    endtask

    task automatic wr_txn(input logic [7:0] p, input bq_t data, input string tag);
        logic a;
        i2c_start();
        write_byte(8'hCC, a); chk({tag, "_aack"}, a, 1'b1);
        chk({tag, "_busy"}, busy, 1'b1);
        write_byte(p, a);     chk({tag, "_pack"}, a, 1'b1);
        mp = p;
        foreach (data[i]) begin
            write_byte(data[i], a); chk({tag, "_dack"}, a, 1'b1);
            if (mp < 12) m[mp] = data[i];
            if (mp == 7)  exp_wr++;
            if (mp == 11) exp_rd++;
            mp = (mp + 1) % 16;
        end
        i2c_stop();
        chk({tag, "_busy_end"}, busy, 1'b0);
    endtask

    task automatic rd_txn(input logic [7:0] p, input int n, input string tag);
        logic a;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hCC, a); chk({tag, "_aack"}, a, 1'b1);
        write_byte(p, a);     chk({tag, "_pack"}, a, 1'b1);
        mp = p;
        i2c_start();
        write_byte(8'hCD, a); chk({tag, "_raack"}, a, 1'b1);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            chk({tag, "_rdata"}, d, m[mp]);
            mp = (mp + 1) % 16;
        end
        i2c_stop();
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_waddr"}, bif.bus_waddr, {m[0], m[1], m[2], m[3]});
        chk({tag, "_wdata"}, bif.bus_wdata, {m[4], m[5], m[6], m[7]});
        chk({tag, "_raddr"}, bif.bus_raddr, {m[8], m[9], m[10], m[11]});
        chk({tag, "_wr_cnt"}, wr_hi, exp_wr);
        chk({tag, "_rd_cnt"}, rd_hi, exp_rd);
    endtask

    task automatic rvalid_pulse(input logic [31:0] v);
        @(negedge clk);
        bif.bus_rdata = v; bif.bus_rvalid = 1'b1;
        @(negedge clk);
        bif.bus_rvalid = 1'b0;
        m[12] = v[31:24]; m[13] = v[23:16]; m[14] = v[15:8]; m[15] = v[7:0];
    endtask

    initial begin
        bq_t q;
        logic a;
        int oe0, wr0, rd0, len;
        logic [7:0] p;
        bif.bus_rdata = '0;
        bif.bus_rvalid = 1'b0;
        mdl_reset();
        clks(3);
        // Reset state
        chk("rst_sda_o", sda_o, 1'b0);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr", bif.bus_wr, 1'b0);
        chk("rst_rd", bif.bus_rd, 1'b0);
        rst_n = 1'b1;
        clks(5);
        chk_outputs("rst");

        // Write address and data, one write strobe
        q = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        wr_txn(8'h00, q, "wr8");
        chk_outputs("wr8");
        chk("wr8_waddr_c", bif.bus_waddr, 32'h11223344);
        chk("wr8_wdata_c", bif.bus_wdata, 32'hAABBCCDD);
        chk("wr8_waddr_strobe", waddr_at_wr, 32'h11223344);
        chk("wr8_wdata_strobe", wdata_at_wr, 32'hAABBCCDD);

        // Read address, read strobe, read-back of returned data
        q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        wr_txn(8'h08, q, "raddr");
        chk_outputs("raddr");
        chk("raddr_c", bif.bus_raddr, 32'hDEADBEEF);
        chk("raddr_strobe", raddr_at_rd, 32'hDEADBEEF);
        rvalid_pulse(32'h12345678);
        rd_txn(8'h0C, 4, "rdback");
        chk_outputs("rdback");

        // Foreign device address: no ACK at all, not busy
        oe0 = oe_cnt; wr0 = wr_hi; rd0 = rd_hi;
        i2c_start();
        write_byte(8'hAA, a); chk("foreign_ack", a, 1'b0);
        chk("foreign_busy", busy, 1'b0);
        write_byte(8'h07, a); chk("foreign_dack", a, 1'b0);
        i2c_stop();
        chk("foreign_oe", oe_cnt, oe0);
        chk("foreign_wr", wr_hi, wr0);
        chk("foreign_rd", rd_hi, rd0);

        // Out-of-range pointer: NACK, data ignored
        i2c_start();
        write_byte(8'hCC, a); chk("badptr_aack", a, 1'b1);
        write_byte(8'h20, a); chk("badptr_pack", a, 1'b0);
        write_byte(8'h99, a); chk("badptr_d0", a, 1'b0);
        write_byte(8'h55, a); chk("badptr_d1", a, 1'b0);
        i2c_stop();
        chk_outputs("badptr");

        // Write at 0x0F is dropped, pointer wraps to 0x00
        q = {8'h01, 8'h02};
        wr_txn(8'h0F, q, "wrap");
        chk_outputs("wrap");
        chk("wrap_waddr_c", bif.bus_waddr, 32'h02223344);

        // STOP mid-byte discards the partial byte
        i2c_start();
        write_byte(8'hCC, a); chk("part_aack", a, 1'b1);
        write_byte(8'h04, a); chk("part_pack", a, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        i2c_stop();
        chk_outputs("part");

        // Reset during an address ACK releases SDA immediately
        i2c_start();
        send8(8'hCC);
        clks(2); sda_m = 1'b1; clks(8);
        chk("mid_ack_oe", sda_oe, 1'b1);
        chk("mid_ack_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_oe", sda_oe, 1'b0);
        chk("rst_async_busy", busy, 1'b0);
        clks(3);
        rst_n = 1'b1;
        mdl_reset();
        i2c_stop();
        chk_outputs("after_rst");
        q = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        wr_txn(8'h00, q, "post_rst");
        chk_outputs("post_rst");

        // Randomized write / read-return / read-back traffic
        for (int it = 0; it < 10; it++) begin
            q = {};
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            p = 8'($urandom_range(0, 15));
            wr_txn(p, q, "rnd_wr");
            if ($urandom_range(0, 2) == 0) rvalid_pulse($urandom);
            p = 8'($urandom_range(0, 15));
            rd_txn(p, $urandom_range(1, 5), "rnd_rd");
            chk_outputs("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
